// File: rtl/pipe_pkg.sv
// Shared pipeline-register types: occupancy type, per-stage control structs
// and their reset constants. Optional skid entry: PIPE_STAGE_SKID_EN.
package pipe_pkg;

   typedef logic [1:0] occ_t;

   typedef struct packed {
      logic       predict_taken;
      logic [1:0] exc_code;
   } ctrl_ifid_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [2:0] alu_control;
      logic       alu_src;
      logic [1:0] imm_src;
   } ctrl_idex_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
   } ctrl_exmem_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
   } ctrl_memwb_t;

   localparam int unsigned IFID_CTRL_W  = $bits(ctrl_ifid_t);
   localparam int unsigned IDEX_CTRL_W  = $bits(ctrl_idex_t);
   localparam int unsigned EXMEM_CTRL_W = $bits(ctrl_exmem_t);
   localparam int unsigned MEMWB_CTRL_W = $bits(ctrl_memwb_t);

   localparam ctrl_ifid_t  IFID_CTRL_RST  = '0;
   localparam ctrl_idex_t  IDEX_CTRL_RST  = '0;
   localparam ctrl_exmem_t EXMEM_CTRL_RST = '0;
   localparam ctrl_memwb_t MEMWB_CTRL_RST = '0;

   // Number of valid entries among head and skid.
   function automatic occ_t occ_count(input logic a, input logic b);
      return occ_t'({1'b0, a}) + occ_t'({1'b0, b});
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit, control field and payload with load/clear.
module pipe_slot #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 16,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic              drop,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // Clear wipes the whole entry; drop only invalidates it, keeping contents.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= CTRL_RST;
      end else if (load) begin
         valid <= 1'b1;
         data  <= d_data;
         ctrl  <= d_ctrl;
      end else if (drop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with stall/flush.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 16,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);

   logic              head_valid;
   logic [DATA_W-1:0] head_data;
   logic [CTRL_W-1:0] head_ctrl;
   logic              head_load;
   logic              head_drop;
   logic [DATA_W-1:0] head_d_data;
   logic [CTRL_W-1:0] head_d_ctrl;
   logic              in_fire;
   logic              out_fire;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign out_valid = head_valid & ~stall;
   assign out_data  = head_data;
   // Bubbles never expose stale control bits downstream.
   assign out_ctrl  = head_valid ? head_ctrl : CTRL_RST;

   pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
   ) u_head (
      .clk    (clk),
      .reset  (reset),
      .clear  (flush),
      .load   (head_load),
      .drop   (head_drop),
      .d_data (head_d_data),
      .d_ctrl (head_d_ctrl),
      .valid  (head_valid),
      .data   (head_data),
      .ctrl   (head_ctrl)
   );

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              skid_load;
   logic              skid_drop;

   // Readiness depends only on local state, never on out_ready.
   assign in_ready  = ~skid_valid & ~stall;
   assign occupancy = occ_count(head_valid, skid_valid);

   pipe_slot #(
      .DATA_W   (DATA_W),
      .CTRL_W   (CTRL_W),
      .CTRL_RST (CTRL_RST)
   ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .clear  (flush),
      .load   (skid_load),
      .drop   (skid_drop),
      .d_data (in_data),
      .d_ctrl (in_ctrl),
      .valid  (skid_valid),
      .data   (skid_data),
      .ctrl   (skid_ctrl)
   );

   // FIFO steering between input, skid and head; flush overrides everything.
   always_comb begin
      head_load   = 1'b0;
      head_drop   = 1'b0;
      skid_load   = 1'b0;
      skid_drop   = 1'b0;
      head_d_data = in_data;
      head_d_ctrl = in_ctrl;
      if (!flush) begin
         if (out_fire) begin
            if (skid_valid) begin
               head_load   = 1'b1;
               head_d_data = skid_data;
               head_d_ctrl = skid_ctrl;
               skid_load   = in_fire;
               skid_drop   = ~in_fire;
            end else if (in_fire) begin
               head_load = 1'b1;
            end else begin
               head_drop = 1'b1;
            end
         end else if (in_fire) begin
            if (head_valid) begin
               skid_load = 1'b1;
            end else begin
               head_load = 1'b1;
            end
         end
      end
   end
`else
   assign in_ready  = (~head_valid | out_ready) & ~stall;
   assign occupancy = occ_count(head_valid, 1'b0);

   // Single entry: load on accept, invalidate when drained without refill.
   always_comb begin
      head_d_data = in_data;
      head_d_ctrl = in_ctrl;
      head_load   = in_fire & ~flush;
      head_drop   = out_fire & ~in_fire & ~flush;
   end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers into one reusable block. Carries a data payload plus a separately-cleared control field. Adds a valid bit, ready/valid back-pressure, stall and flush with defined priority, and an optional two-entry skid buffer. Sits between any two adjacent stages of the pipelined processor datapath.

## Interface
- DATA_W, 32: payload width in bits (operands, extend value, ALU result, PC).
- CTRL_W, 16: control-field width (RegWrite, MemWrite, ALUControl, flags, …).
- CTRL_RST, '0: value loaded into the control field on reset or flush.
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold stage contents; blocks input and output transfers.
- flush  in  1  discard all held entries (bubble insertion).
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head-entry payload.
- out_ctrl  out  CTRL_W  head-entry control field.
- occupancy  out  2  number of held entries (0..2).

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = head_valid & ~stall; out_data/out_ctrl always show head entry.
- Stall: in_ready = 0, out_valid = 0, all state held.
- Flush (sync): all entries invalid, ctrl = CTRL_RST, data = 0, occupancy = 0. Priority: reset > flush > stall > normal. An in_fire coinciding with flush is dropped (the producer sees completion; the entry is squashed by design).
- Single-entry mode (no skid): in_ready = (~head_valid | out_ready) & ~stall. On in_fire, load head. On out_fire without in_fire, clear head_valid, leaving ctrl and data unchanged.
- Simultaneous in_fire and out_fire: head is replaced. occupancy is unchanged.
- A bubble (head_valid = 0) always reports out_ctrl = CTRL_RST, so downstream never sees stale write-enables.

## Timing
- Latency: in_fire at cycle N → out_valid at N+1 (absent stall/flush).
- Throughput: one entry per cycle with out_ready held high.
- Reset values: out_valid 0, out_data 0, out_ctrl CTRL_RST, occupancy 0. in_ready is 1 once reset deasserts, provided stall = 0.
- Reset or flush asserted mid-stream takes effect at that posedge; the next cycle is empty.
- Stall released: the held entry is presented the same cycle stall falls.

## Configuration
- PIPE_STAGE_SKID_EN defined: adds a second (skid) entry.
  - in_ready = ~skid_valid & ~stall, with no combinational path from out_ready.
  - in_fire while head is valid and not leaving → entry goes to skid.
  - out_fire with skid valid → skid moves to head the same edge, and a concurrent in_fire fills skid.
  - Order is strictly FIFO. occupancy ranges 0..2.
- Undefined: single entry only. occupancy never exceeds 1. in_ready depends combinationally on out_ready.

## Structure
- Shared package pipe_pkg holds:
  - occ_t (logic [1:0]);
  - per-stage control structs (ctrl_ifid_t, ctrl_idex_t, ctrl_exmem_t, ctrl_memwb_t), with CTRL_W derived via $bits;
  - matching *_CTRL_RST constants.
- Sub-module pipe_slot: one valid+ctrl+data register with load/clear inputs. It is instantiated once for head and, under PIPE_STAGE_SKID_EN, once more for skid.

## Test plan
- Reset then idle: reset=1 for 2 cycles → out_valid 0, out_ctrl CTRL_RST, occupancy 0, in_ready 1.
- Stream: in_data 1..8 on consecutive cycles, out_ready 1 → out_data 1..8 one cycle later each, no gaps.
- Stall: assert stall for 3 cycles while holding entry 0xA5 → out_valid 0, in_ready 0, occupancy 1. Release → 0xA5 presented immediately.
- Flush priority: stall=1, flush=1, in_valid=1 with in_data 0x55 → next cycle out_valid 0, out_ctrl CTRL_RST, occupancy 0, 0x55 never emitted.
- Back-pressure (skid): out_ready=0, push 0x11 then 0x22 → occupancy 2, in_ready 0. Raise out_ready → out 0x11 then 0x22, in order.
- Back-pressure (no skid): out_ready=0 with entry held → in_ready 0. Raise out_ready with in_valid → in_ready 1, replace-in-place, occupancy stays 1.
